// File: rtl/mult_unit.sv
// mult_unit -- iterative 32x32 -> 64-bit multiplier for MULT / MULTU.
//
// Works on operand magnitudes with a shift-add loop, then applies the sign
// to the 64-bit product in two 32-bit halves. All arithmetic (absolute value,
// partial-product accumulate, two's-complement negate) shares one 32-bit
// adder. Latency is fixed: a start accepted at edge k produces done and new
// hi/lo at edge k+36.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request, accepted only when busy = 0 (IDLE or DONE)
//   is_signed  1 = MULT (two's complement), 0 = MULTU; sampled with start
//   op_a       multiplicand (rs); sampled with start
//   op_b       multiplier (rt); sampled with start
//   busy       operation in progress
//   done       one-cycle pulse, hi/lo just updated
//   hi, lo     upper / lower 32 bits of the last product

// 32-bit ripple-style adder shared by every arithmetic step of the multiplier.
//   a, b   addends
//   c_in   carry in
//   sum    low 32 bits of a + b + c_in
//   c_out  carry out
module adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module mult_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ABS_A  = 3'd1,
      ABS_B  = 3'd2,
      RUN    = 3'd3,
      NEG_LO = 3'd4,
      NEG_HI = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] acc_q,   acc_d;
   logic [31:0] mplr_q,  mplr_d;
   logic        sgn_q,   sgn_d;     // latched is_signed
   logic        neg_q,   neg_d;     // product must be negated
   logic [4:0]  cnt_q,   cnt_d;
   logic        nc_q,    nc_d;      // carry from low-half negate into high half
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;

   logic [31:0] add_a, add_b, add_sum;
   logic        add_ci, add_co;

   adder_32bit u_adder (
      .a     (add_a),
      .b     (add_b),
      .c_in  (add_ci),
      .sum   (add_sum),
      .c_out (add_co)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mplr_d  = mplr_q;
      sgn_d   = sgn_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      nc_d    = nc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      add_a   = 32'd0;
      add_b   = 32'd0;
      add_ci  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            // Raw operands are parked in mcand/mplr; the ABS states
            // replace them in place with their magnitudes.
            if (start) begin
               mcand_d = op_a;
               mplr_d  = op_b;
               sgn_d   = is_signed;
               neg_d   = is_signed & (op_a[31] ^ op_b[31]);
               state_d = ABS_A;
            end else begin
               state_d = IDLE;
            end
         end
         ABS_A: begin
            // ~x + 1; 0x80000000 maps to itself, which is also its magnitude.
            add_a  = ~mcand_q;
            add_ci = 1'b1;
            if (sgn_q & mcand_q[31]) mcand_d = add_sum;
            state_d = ABS_B;
         end
         ABS_B: begin
            add_a  = ~mplr_q;
            add_ci = 1'b1;
            if (sgn_q & mplr_q[31]) mplr_d = add_sum;
            acc_d   = 32'd0;
            cnt_d   = 5'd0;
            state_d = RUN;
         end
         RUN: begin
            // One shift-add step: {acc,mplr} is a 65-bit right shift with the
            // adder carry entering at the top. Product bits fill mplr from
            // the left as multiplier bits leave on the right.
            add_a = acc_q;
            add_b = mplr_q[0] ? mcand_q : 32'd0;
            {acc_d, mplr_d} = {add_co, add_sum, mplr_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = NEG_LO;
         end
         NEG_LO: begin
            add_a  = ~mplr_q;
            add_ci = 1'b1;
            if (neg_q) begin
               mplr_d = add_sum;
               nc_d   = add_co;
            end else begin
               nc_d   = 1'b0;
            end
            state_d = NEG_HI;
         end
         NEG_HI: begin
            // High half of the 64-bit negate: ~acc plus carry out of the low
            // half, so a zero product stays zero instead of 0xFFFFFFFF_00000000.
            add_a  = ~acc_q;
            add_ci = nc_q;
            hi_d   = neg_q ? add_sum : acc_q;
            lo_d   = mplr_q;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ABS_A) || (state_d == ABS_B) || (state_d == RUN) ||
               (state_d == NEG_LO) || (state_d == NEG_HI);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mcand_q <= 32'd0;
         acc_q   <= 32'd0;
         mplr_q  <= 32'd0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         cnt_q   <= 5'd0;
         nc_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mplr_q  <= mplr_d;
         sgn_q   <= sgn_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         nc_q    <= nc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mult_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference product from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      longint sa, sb;
      logic [63:0] ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   // Called #1 after a clock edge. Presents a request, waits for done with a
   // bounded budget and checks latency, busy profile and product.
   // Returns positioned #1 after the done edge (inside the done cycle).
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
      logic [63:0] exp;
      int          lat;
      logic        busy_ok;
      exp       = ref_prod(a, b, s);
      start     = 1'b1;
      is_signed = s;
      op_a      = a;
      op_b      = b;
      @(posedge clk); #1;
      start     = 1'b0;
      op_a      = $urandom;
      op_b      = $urandom;
      is_signed = 1'($urandom);
      lat       = 0;
      busy_ok   = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd36);
      chk({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
      chk({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
      chk({tag, " product"}, {hi, lo}, exp);
   endtask

   logic [31:0] ra, rb, hold_hi, hold_lo;
   int          wait_n;

   initial begin
      reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("multu 7x6", 32'd7, 32'd6, 1'b0);
      chk("7x6 exact", {hi, lo}, 64'h0000_0000_0000_002A);
      run_op("multu ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("ffxff exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // done is a single pulse and hi/lo hold afterwards.
      hold_hi = hi; hold_lo = lo;
      @(posedge clk); #1;
      chk("done pulse", {63'd0, done}, 64'd0);
      chk("hilo hold", {hi, lo}, {hold_hi, hold_lo});

      run_op("mult -3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
      chk("-3x5 exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      @(posedge clk); #1;
      run_op("mult minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
      chk("minxmin exact", {hi, lo}, 64'h4000_0000_0000_0000);
      run_op("mult 0x-1", 32'd0, 32'hFFFF_FFFF, 1'b1);
      chk("0x-1 exact", {hi, lo}, 64'd0);
      run_op("multu 80x80", 32'h8000_0000, 32'h8000_0000, 1'b0);
      @(posedge clk); #1;

      // Start 2x3, ignored 9x9 at cycle 10, back-to-back 4x4 in done cycle.
      start = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_n = 10;
      while (!done && wait_n < 40) begin
         @(posedge clk); #1;
         wait_n++;
      end
      chk("b2b first latency", 64'(wait_n), 64'd36);
      chk("b2b first lo", {hi, lo}, 64'd6);
      run_op("b2b 4x4", 32'd4, 32'd4, 1'b0);
      chk("b2b second lo", {hi, lo}, 64'd16);
      @(posedge clk); #1;

      // Reset in the middle of an operation.
      start = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd1000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset busy", {63'd0, busy}, 64'd0);
      chk("midreset done", {63'd0, done}, 64'd0);
      chk("midreset hilo", {hi, lo}, 64'd0);
      run_op("after reset", 32'd123456, 32'd654321, 1'b0);

      // Randomized operations, biased toward sign/extreme values.
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         if (($urandom & 1) == 0) @(posedge clk);
         #0;
         run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
